// File: rtl/buf_pipe.sv
// buf_pipe: elastic inter-stage buffer for the MIPS datapath.
// Holds CHANNELS data words plus an ALU-function field in a DEPTH-entry FIFO.
// Handshake is valid/ready, flush squashes all entries, and stall_cnt saturates.
// An empty stage presents all-zero outputs, so a bubble reads as a nop with func 0.
module buf_pipe #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 2,
   parameter int FUNC_W   = 4,
   parameter int DEPTH    = 2
) (
   input  logic                          clk_bufp,
   input  logic                          reset_bufp,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [CHANNELS*WIDTH-1:0]     in_data,
   input  logic [FUNC_W-1:0]             in_func,
   input  logic                          flush,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [CHANNELS*WIDTH-1:0]     out_data,
   output logic [FUNC_W-1:0]             out_func,
   output logic [$clog2(DEPTH+1)-1:0]    count,
   output logic [15:0]                   stall_cnt
);

   localparam int DATA_W  = CHANNELS * WIDTH;
   localparam int ENTRY_W = DATA_W + FUNC_W;
   localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W   = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   // Each entry is stored as {data, func}.
   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [ENTRY_W-1:0] head;
   logic               push;
   logic               pop;

   // Handshake status comes from registered occupancy only; flush blocks both transfers.
   always_comb begin
      in_ready  = (count < FULL_CNT);
      out_valid = (count != '0);
      push      = in_valid & in_ready & ~flush;
      pop       = out_valid & out_ready & ~flush;
   end

   // Head entry is driven out only while valid, so a bubble is all-zero.
   always_comb begin
      head     = mem[rd_ptr];
      out_data = '0;
      out_func = '0;
      if (out_valid) begin
         out_data = head[ENTRY_W-1 -: DATA_W];
         out_func = head[FUNC_W-1:0];
      end
   end

   // Storage: cleared on reset, written at wr_ptr on push; flush leaves contents alone.
   always_ff @(posedge clk_bufp or posedge reset_bufp) begin
      if (reset_bufp) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[wr_ptr] <= {in_data, in_func};
      end
   end

   // Pointers and occupancy: flush wins over any transfer in the same cycle.
   always_ff @(posedge clk_bufp or posedge reset_bufp) begin
      if (reset_bufp) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Saturating count of cycles where upstream offers an entry that is refused.
   always_ff @(posedge clk_bufp or posedge reset_bufp) begin
      if (reset_bufp) begin
         stall_cnt <= '0;
      end else if (in_valid && !in_ready && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

endmodule
